// File: rtl/instr_mem_responder.sv
// Instruction-fetch memory responder: single-outstanding request, fixed-latency
// valid/ready response from on-chip RAM, with a write port for program load and stores.
module instr_mem_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_err,
    input  logic                  wr_en,
    input  logic [31:0]           wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    localparam int          DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [2:0]  LAT_LAST = 3'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // A byte address is usable only if word aligned and inside the RAM window.
    function automatic logic addr_ok(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && ((addr >> (ADDR_WIDTH + 2)) == 32'd0);
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    state_t                r_state;
    logic [2:0]            r_lat_cnt;
    logic                  r_resp_valid;
    logic [DATA_WIDTH-1:0] r_resp_data;
    logic                  r_resp_err;

    state_t                w_next_state;
    logic                  w_accept;
    logic                  w_handshake;
    logic                  w_lat_done;
    logic                  w_req_ok;
    logic                  w_wr_ok;
    logic [DATA_WIDTH-1:0] w_rd_word;

    assign req_ready   = (r_state == ST_IDLE) & reset_n;
    assign w_accept    = req_valid & req_ready;
    assign w_handshake = r_resp_valid & resp_ready;
    assign w_lat_done  = (r_lat_cnt == LAT_LAST);
    assign w_req_ok    = addr_ok(req_addr);
    assign w_wr_ok     = addr_ok(wr_addr);
    // Read happens before this edge's write lands, so a same-edge write returns the old word.
    assign w_rd_word   = r_mem[req_addr[ADDR_WIDTH+1:2]];

    assign resp_valid  = r_resp_valid;
    assign resp_data   = r_resp_data;
    assign resp_err    = r_resp_err;

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (wr_en && w_wr_ok) begin
            r_mem[wr_addr[ADDR_WIDTH+1:2]] <= wr_data;
        end
    end

    // Next-state logic for the request/response sequencer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_WAIT;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (w_lat_done) begin
                    w_next_state = ST_RESP;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (w_handshake) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_RESP;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State, latency counter and registered response outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_lat_cnt    <= 3'd0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= {DATA_WIDTH{1'b0}};
            r_resp_err   <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_resp_valid <= (w_next_state == ST_RESP);
            if ((r_state == ST_WAIT) && !w_lat_done) begin
                r_lat_cnt <= r_lat_cnt + 3'd1;
            end else begin
                r_lat_cnt <= 3'd0;
            end
            if (w_accept) begin
                r_resp_data <= w_req_ok ? w_rd_word : {DATA_WIDTH{1'b0}};
                r_resp_err  <= !w_req_ok;
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: stimulus pushes expected responses into a
// queue, an independent monitor pops and compares on every response handshake.
module tb_instr_mem_responder;

    localparam int LAT = 2;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        wr_en = 1'b0;
    logic [31:0] wr_addr = 32'd0;
    logic [31:0] wr_data = 32'd0;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   n_issued = 0;
    int   n_resp = 0;

    instr_mem_responder #(
        .ADDR_WIDTH(12),
        .DATA_WIDTH(32),
        .LATENCY   (LAT)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data (resp_data),
        .resp_err  (resp_err),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a response is consumed on the edge following a negedge that sees valid&ready.
    always @(negedge clock) begin
        if (reset_n && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp actual=%h expected=none t=%0t", resp_data, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_data", resp_data, e.data);
                check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                n_resp++;
            end
        end
    end

    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        @(posedge clock);
        #1;
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clock);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic do_req(input logic [31:0] a, input logic [31:0] exp_d, input logic exp_e,
                          input int bp, input logic same_wr,
                          input logic [31:0] wa, input logic [31:0] wd);
        exp_t e;
        @(posedge clock);
        #1;
        req_valid  = 1'b1;
        req_addr   = a;
        resp_ready = (bp == 0);
        wr_en      = same_wr;
        wr_addr    = wa;
        wr_data    = wd;
        e.data = exp_d;
        e.err  = exp_e;
        exp_q.push_back(e);
        n_issued++;
        @(negedge clock);
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_addr  = 32'hA5A5_0003;
        wr_en     = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            @(negedge clock);
            check("resp_valid_early", {31'd0, resp_valid}, 32'd0);
            check("req_ready_busy", {31'd0, req_ready}, 32'd0);
        end
        @(negedge clock);
        check("resp_valid_lat", {31'd0, resp_valid}, 32'd1);
        for (int b = 0; b < bp; b++) begin
            @(posedge clock);
            @(negedge clock);
            check("bp_valid_hold", {31'd0, resp_valid}, 32'd1);
            check("bp_data_hold", resp_data, exp_d);
            check("bp_req_ready", {31'd0, req_ready}, 32'd0);
        end
        if (bp > 0) begin
            @(posedge clock);
            #1;
            resp_ready = 1'b1;
        end
        @(posedge clock);
        @(negedge clock);
        check("post_hs_valid", {31'd0, resp_valid}, 32'd0);
        check("post_hs_ready", {31'd0, req_ready}, 32'd1);
        check("post_hs_data_keep", resp_data, exp_d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("rst_req_ready", {31'd0, req_ready}, 32'd0);
            check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
            check("rst_resp_data", resp_data, 32'd0);
        end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        check("rel_req_ready", {31'd0, req_ready}, 32'd1);
        check("rel_resp_valid", {31'd0, resp_valid}, 32'd0);

        write_word(32'h10, 32'hDEAD_BEEF);
        do_req(32'h10, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, 32'd0, 32'd0);
        do_req(32'h10, 32'hDEAD_BEEF, 1'b0, 5, 1'b0, 32'd0, 32'd0);

        do_req(32'h12, 32'h0, 1'b1, 0, 1'b0, 32'd0, 32'd0);
        do_req(32'h4000, 32'h0, 1'b1, 0, 1'b0, 32'd0, 32'd0);
        // Dropped writes: misaligned, and out-of-range aliasing onto word 0x10.
        write_word(32'h13, 32'h5555_5555);
        write_word(32'h4010, 32'h6666_6666);
        do_req(32'h10, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, 32'd0, 32'd0);
        write_word(32'h3FFC, 32'h1234_5678);
        do_req(32'h3FFC, 32'h1234_5678, 1'b0, 0, 1'b0, 32'd0, 32'd0);

        write_word(32'h20, 32'h2222_2222);
        do_req(32'h20, 32'h2222_2222, 1'b0, 0, 1'b1, 32'h20, 32'h1111_1111);
        do_req(32'h20, 32'h1111_1111, 1'b0, 0, 1'b0, 32'd0, 32'd0);

        // Reset during WAIT drops the pending request.
        @(posedge clock);
        #1;
        req_valid = 1'b1;
        req_addr  = 32'h10;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(negedge clock);
        check("midrst_req_ready", {31'd0, req_ready}, 32'd0);
        check("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("dropped_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        check("after_rst_ready", {31'd0, req_ready}, 32'd1);
        check("after_rst_data", resp_data, 32'd0);
        do_req(32'h10, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, 32'd0, 32'd0);

        repeat (4) @(posedge clock);
        @(negedge clock);
        check("resp_count", n_resp, n_issued);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
